// File: rtl/de0_input_pkg.sv
// -----------------------------------------------------------------------------
// de0_input_pkg
// Shared definitions for the DE0 pushbutton input path:
//   - button index constants (increment, decrement, clear)
//   - press-FSM state type and state encodings
//   - default timing constants for a 50 MHz clock
//   - width helper for counters and timers
// -----------------------------------------------------------------------------
package de0_input_pkg;

   localparam int BTN_INC = 0;
   localparam int BTN_DEC = 1;
   localparam int BTN_CLR = 2;
   localparam int NUM_BTN = 3;

   // 20 ms debounce, 0.5 s before auto-repeat, 0.1 s between repeats at 50 MHz
   localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
   localparam int DEF_REPEAT_DELAY    = 25_000_000;
   localparam int DEF_REPEAT_PERIOD   = 5_000_000;

   typedef logic [1:0] press_state_t;

   localparam press_state_t PRESS_IDLE   = 2'd0;
   localparam press_state_t PRESS_HOLD   = 2'd1;
   localparam press_state_t PRESS_REPEAT = 2'd2;

   // Bits needed to hold values 0..n-1, never less than one bit
   function automatic int width_for(input int n);
      int w;
      w = $clog2(n);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/de0_debounce.sv
// -----------------------------------------------------------------------------
// de0_debounce
// Single-bit synchronizer plus debouncer for one active-low board pushbutton.
// The raw level passes through two flops, is inverted to an active-high
// "pressed" level, and is only accepted into db after it has differed from
// the current db for DEBOUNCE_CYCLES consecutive cycles.
//
// Ports:
//   clk_50   in  1  system clock
//   reset    in  1  synchronous active-high reset
//   button_n in  1  raw asynchronous pushbutton, active-low
//   db       out 1  debounced pressed level, active-high (registered)
// -----------------------------------------------------------------------------
module de0_debounce
   import de0_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)
(
   input  logic clk_50,
   input  logic reset,
   input  logic button_n,
   output logic db
);

   localparam int CNT_W = width_for(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_r;
   logic             sync2_r;
   logic             pressed_s;
   logic             db_r;
   logic [CNT_W-1:0] cnt_r;

   // Two-flop synchronizer; reset loads the released (high) level
   always_ff @(posedge clk_50) begin
      if (reset) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= button_n;
         sync2_r <= sync1_r;
      end
   end

   assign pressed_s = ~sync2_r;

   // Stability counter: any cycle matching db restarts the count
   always_ff @(posedge clk_50) begin
      if (reset) begin
         db_r  <= 1'b0;
         cnt_r <= {CNT_W{1'b0}};
      end else if (pressed_s == db_r) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
         db_r  <= pressed_s;
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   assign db = db_r;

endmodule

// File: rtl/de0_button_counter.sv
// -----------------------------------------------------------------------------
// de0_button_counter
// Turns the three DE0 pushbuttons into increment / decrement / clear
// operations on a 16-bit value that drives the 7-segment display path.
// Increment and decrement auto-repeat while held; clear fires once per press.
//
// Ports:
//   clk_50  in  1   50 MHz clock
//   reset   in  1   synchronous active-high reset
//   BUTTON  in  3   raw pushbuttons, active-low: [0] inc, [1] dec, [2] clear
//   value   out 16  current count (registered)
//   step    out 3   one-cycle pulse per applied operation, per button
// -----------------------------------------------------------------------------
module de0_button_counter
   import de0_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
)
(
   input  logic        clk_50,
   input  logic        reset,
   input  logic [2:0]  BUTTON,
   output logic [15:0] value,
   output logic [2:0]  step
);

   localparam int TMR_W = width_for((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
   localparam logic [TMR_W-1:0] DELAY_LOAD  = TMR_W'(REPEAT_DELAY - 1);
   localparam logic [TMR_W-1:0] PERIOD_LOAD = TMR_W'(REPEAT_PERIOD - 1);

   logic [NUM_BTN-1:0] db_s;
   press_state_t       state_r [NUM_BTN];
   logic [TMR_W-1:0]   timer_r [NUM_BTN];
   logic [NUM_BTN-1:0] step_r;
   logic [15:0]        value_r;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      de0_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk_50   (clk_50),
         .reset    (reset),
         .button_n (BUTTON[g]),
         .db       (db_s[g])
      );
   end

   // Press FSMs: initial step on press, then delayed auto-repeat for inc/dec.
   // IDLE with db high can only mean a fresh rising edge, since any fall
   // sends the FSM back to IDLE and reset clears db alongside the FSM.
   always_ff @(posedge clk_50) begin
      if (reset) begin
         for (int i = 0; i < NUM_BTN; i++) begin
            state_r[i] <= PRESS_IDLE;
            timer_r[i] <= {TMR_W{1'b0}};
         end
         step_r <= 3'b000;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            step_r[i] <= 1'b0;
            case (state_r[i])
               PRESS_IDLE: begin
                  if (db_s[i]) begin
                     state_r[i] <= PRESS_HOLD;
                     timer_r[i] <= DELAY_LOAD;
                     step_r[i]  <= 1'b1;
                  end else begin
                     state_r[i] <= PRESS_IDLE;
                  end
               end
               PRESS_HOLD: begin
                  if (!db_s[i]) begin
                     state_r[i] <= PRESS_IDLE;
                  end else if (timer_r[i] != {TMR_W{1'b0}}) begin
                     timer_r[i] <= timer_r[i] - TMR_W'(1);
                  end else if (i != BTN_CLR) begin
                     state_r[i] <= PRESS_REPEAT;
                     timer_r[i] <= PERIOD_LOAD;
                     step_r[i]  <= 1'b1;
                  end else begin
                     // clear parks here with the timer at zero until release
                     state_r[i] <= PRESS_HOLD;
                  end
               end
               PRESS_REPEAT: begin
                  if (!db_s[i]) begin
                     state_r[i] <= PRESS_IDLE;
                  end else if (timer_r[i] != {TMR_W{1'b0}}) begin
                     timer_r[i] <= timer_r[i] - TMR_W'(1);
                  end else begin
                     timer_r[i] <= PERIOD_LOAD;
                     step_r[i]  <= 1'b1;
                  end
               end
               default: begin
                  state_r[i] <= PRESS_IDLE;
                  timer_r[i] <= {TMR_W{1'b0}};
               end
            endcase
         end
      end
   end

   // Value register: clear wins, simultaneous inc+dec cancel, wraps mod 2^16
   always_ff @(posedge clk_50) begin
      if (reset) begin
         value_r <= 16'h0000;
      end else if (step_r[BTN_CLR]) begin
         value_r <= 16'h0000;
      end else if (step_r[BTN_INC] && step_r[BTN_DEC]) begin
         value_r <= value_r;
      end else if (step_r[BTN_INC]) begin
         value_r <= value_r + 16'd1;
      end else if (step_r[BTN_DEC]) begin
         value_r <= value_r - 16'd1;
      end else begin
         value_r <= value_r;
      end
   end

   assign value = value_r;
   assign step  = step_r;

endmodule

// File: tb/tb_de0_button_counter.sv
// -----------------------------------------------------------------------------
// tb_de0_button_counter
// Directed self-checking bench for de0_button_counter with small timing
// parameters (debounce 4, repeat delay 20, repeat period 5).
// -----------------------------------------------------------------------------
module tb_de0_button_counter;

   logic        clk_50;
   logic        reset;
   logic [2:0]  BUTTON;
   logic [15:0] value;
   logic [2:0]  step;

   int checks;
   int errors;
   int cyc;
   int step_cnt [3];
   int both_seen;
   int s0_times [$];

   de0_button_counter #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (20),
      .REPEAT_PERIOD   (5)
   ) dut (
      .clk_50 (clk_50),
      .reset  (reset),
      .BUTTON (BUTTON),
      .value  (value),
      .step   (step)
   );

   initial clk_50 = 1'b0;
   always #5 clk_50 = ~clk_50;

   // One clock; outputs are sampled 1 ns after the edge and pulses tallied
   task automatic tick();
      @(posedge clk_50);
      #1;
      cyc++;
      for (int b = 0; b < 3; b++) begin
         if (step[b] === 1'b1) step_cnt[b]++;
      end
      if (step[0] === 1'b1) s0_times.push_back(cyc);
      if (step[0] === 1'b1 && step[1] === 1'b1) both_seen++;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic clear_tally();
      for (int b = 0; b < 3; b++) step_cnt[b] = 0;
      both_seen = 0;
      s0_times.delete();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Press the buttons in mask for hold cycles, then release for rel cycles
   task automatic press(input logic [2:0] mask, input int hold, input int rel);
      BUTTON = BUTTON & ~mask;
      run(hold);
      BUTTON = BUTTON | mask;
      run(rel);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      run(2);
      reset = 1'b0;
   endtask

   initial begin
      int t0;
      int n;
      checks = 0;
      errors = 0;
      cyc    = 0;
      BUTTON = 3'b111;
      reset  = 1'b0;
      clear_tally();

      // Reset with all buttons released
      do_reset();
      check("reset_value", 32'(value), 32'h0000);
      check("reset_step", 32'(step), 32'h0);

      // Bounce: 2-cycle toggles, then a 3-cycle low, all shorter than debounce
      clear_tally();
      for (int k = 0; k < 10; k++) begin
         BUTTON[0] = 1'b0;
         run(2);
         BUTTON[0] = 1'b1;
         run(2);
      end
      press(3'b001, 3, 10);
      check("bounce_no_step", 32'(step_cnt[0]), 32'd0);
      check("bounce_value", 32'(value), 32'h0000);

      // Clean 10-cycle press: one step, value 1
      press(3'b001, 10, 10);
      check("clean_press_steps", 32'(step_cnt[0]), 32'd1);
      check("clean_press_value", 32'(value), 32'h0001);

      // Auto-repeat: steps at t0, t0+20, then every 5 cycles up to t0+60
      clear_tally();
      BUTTON[0] = 1'b0;
      n = 0;
      while (step_cnt[0] == 0 && n < 20) begin
         tick();
         n++;
      end
      check("repeat_first_step", 32'(step_cnt[0]), 32'd1);
      t0 = cyc;
      run(57);
      BUTTON[0] = 1'b1;
      run(20);
      check("repeat_pulse_count", 32'(s0_times.size()), 32'd10);
      for (int k = 1; k < 10; k++) begin
         check("repeat_offset", (k < s0_times.size()) ? 32'(s0_times[k] - t0) : 32'hFFFF_FFFF,
               32'(15 + 5 * k));
      end
      check("repeat_value", 32'(value), 32'h000B);

      // Wrap down from 0 and back up
      do_reset();
      check("wrap_start", 32'(value), 32'h0000);
      press(3'b010, 10, 10);
      check("wrap_down", 32'(value), 32'hFFFF);
      press(3'b001, 10, 10);
      check("wrap_up", 32'(value), 32'h0000);

      // Simultaneous inc+dec from value 1 cancels
      press(3'b001, 10, 10);
      clear_tally();
      press(3'b011, 10, 10);
      check("simul_both_pulsed", 32'(both_seen), 32'd1);
      check("simul_value", 32'(value), 32'h0001);

      // Inc+dec+clear together: clear wins
      press(3'b001, 10, 10);
      check("pre_clear_value", 32'(value), 32'h0002);
      press(3'b111, 10, 10);
      check("clear_priority_value", 32'(value), 32'h0000);

      // Long clear hold never repeats
      press(3'b001, 10, 10);
      clear_tally();
      press(3'b100, 60, 10);
      check("clear_hold_steps", 32'(step_cnt[2]), 32'd1);
      check("clear_hold_value", 32'(value), 32'h0000);

      // Reset mid-press: reach 7 in REPEAT, reset, keep holding
      clear_tally();
      BUTTON[0] = 1'b0;
      n = 0;
      while (step_cnt[0] < 7 && n < 80) begin
         tick();
         n++;
      end
      tick();
      check("midpress_value_7", 32'(value), 32'h0007);
      reset = 1'b1;
      run(2);
      check("midpress_reset_step", 32'(step), 32'h0);
      reset = 1'b0;
      clear_tally();
      n = 0;
      while (step_cnt[0] == 0 && n < 20) begin
         tick();
         n++;
         if (step_cnt[0] == 0) check("midpress_value_zero", 32'(value), 32'h0000);
      end
      check("midpress_latency_window", 32'((n >= 5) && (n <= 7)), 32'd1);
      tick();
      check("midpress_value_after", 32'(value), 32'h0001);
      BUTTON[0] = 1'b1;
      run(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
